param_hash_engine: RTL and testbench

PARAM_HASH_ENGINE -- requirements
Module: param_hash_engine

---
 rtl/param_hash_engine_if.sv | 32 +++
 rtl/param_hash_engine.sv | 126 ++++++++++++
 tb/tb_param_hash_engine.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_hash_engine_if.sv
// Pixel stream, hash result and batch control signals of param_hash_engine.
// The engine uses the slave modport; the driving/consuming side uses master.
interface param_hash_engine_if #(
    parameter int PIX_W = 8,
    parameter int NPIX  = 256,
    parameter int LANES = 4,
    parameter int IDX_W = 16
);
    logic                   start;
    logic [IDX_W-1:0]       num_images;
    logic                   hash_mode;
    logic [IDX_W-1:0]       image_header;
    logic [LANES*PIX_W-1:0] pix_data;
    logic                   pix_valid;
    logic                   pix_ready;
    logic [NPIX-1:0]        hash_value;
    logic [IDX_W-1:0]       image_index_output;
    logic                   hash_valid;
    logic                   hash_ready;
    logic                   busy;
    logic                   hash_calc_done;

    modport slave (
        input  start, num_images, hash_mode, image_header, pix_data, pix_valid, hash_ready,
        output pix_ready, hash_value, image_index_output, hash_valid, busy, hash_calc_done
    );

    modport master (
        output start, num_images, hash_mode, image_header, pix_data, pix_valid, hash_ready,
        input  pix_ready, hash_value, image_index_output, hash_valid, busy, hash_calc_done
    );
endinterface

// File: rtl/param_hash_engine.sv
// Perceptual image hash engine: buffers one image of NPIX pixels, then emits an
// average hash (pixel > mean) or difference hash (pixel > next pixel) per image.
module param_hash_engine #(
    parameter int PIX_W = 8,
    parameter int NPIX  = 256,
    parameter int LANES = 4,
    parameter int IDX_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    param_hash_engine_if.slave  bus
);
    localparam int LOG_NPIX = $clog2(NPIX);
    localparam int BEATS    = NPIX / LANES;
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SUM_W    = PIX_W + LOG_NPIX;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, COMPARE, OUTPUT, DONE} state_t;

    state_t              state, state_nxt;
    logic [PIX_W-1:0]    pix_buf [NPIX];
    logic [BEAT_W-1:0]   cnt;
    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    beat_sum;
    logic [PIX_W-1:0]    mean;
    logic [IDX_W-1:0]    img_cnt, num_q, hdr_q, idx_q;
    logic                mode_q, valid_q;
    logic [NPIX-1:0]     hash_q;
    logic                beat_fire, hash_fire;
    logic [LOG_NPIX-1:0] lane_idx [LANES];
    logic [LOG_NPIX-1:0] nbr_idx  [LANES];
    logic [LANES-1:0]    lane_bits;

    assign beat_fire = bus.pix_valid && (state == LOAD);
    assign hash_fire = valid_q && bus.hash_ready;
    assign mean      = PIX_W'(sum >> LOG_NPIX);

    always_comb begin
        beat_sum = '0;
        for (int unsigned k = 0; k < LANES; k++)
            beat_sum = beat_sum + SUM_W'(bus.pix_data[k*PIX_W +: PIX_W]);
    end

    // One counter serves as beat index in LOAD and lane-group index in COMPARE.
    always_comb begin
        lane_idx  = '{default: '0};
        nbr_idx   = '{default: '0};
        lane_bits = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_idx[k]  = LOG_NPIX'(cnt) * LOG_NPIX'(LANES) + LOG_NPIX'(k);
            nbr_idx[k]   = lane_idx[k] + LOG_NPIX'(1);
            lane_bits[k] = mode_q ? (pix_buf[lane_idx[k]] > pix_buf[nbr_idx[k]])
                                  : (pix_buf[lane_idx[k]] > mean);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = (bus.num_images == '0) ? DONE : LOAD;
            LOAD:    if (beat_fire && cnt == LAST_BEAT) state_nxt = COMPARE;
            COMPARE: if (cnt == LAST_BEAT) state_nxt = OUTPUT;
            OUTPUT:  if (hash_fire) state_nxt = (img_cnt + IDX_W'(1) == num_q) ? DONE : LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            sum     <= '0;
            img_cnt <= '0;
            num_q   <= '0;
            hdr_q   <= '0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            hash_q  <= '0;
        end else begin
            state <= state_nxt;
            // hash_valid rises one cycle after OUTPUT is entered
            valid_q <= (state == OUTPUT) && !hash_fire;
            if (state_nxt != state)
                cnt <= '0;
            else if (beat_fire || state == COMPARE)
                cnt <= cnt + BEAT_W'(1);
            if (state == IDLE && bus.start) begin
                num_q   <= bus.num_images;
                img_cnt <= '0;
            end
            if (state != LOAD && state_nxt == LOAD)
                sum <= '0;
            if (beat_fire) begin
                sum <= sum + beat_sum;
                if (cnt == '0) begin
                    hdr_q  <= bus.image_header;
                    mode_q <= bus.hash_mode;
                end
            end
            if (state == COMPARE) begin
                for (int unsigned k = 0; k < LANES; k++)
                    hash_q[lane_idx[k]] <= lane_bits[k];
                if (state_nxt == OUTPUT)
                    idx_q <= hdr_q;
            end
            if (hash_fire)
                img_cnt <= img_cnt + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (beat_fire)
            for (int unsigned k = 0; k < LANES; k++)
                pix_buf[lane_idx[k]] <= bus.pix_data[k*PIX_W +: PIX_W];
    end

    assign bus.pix_ready          = (state == LOAD);
    assign bus.hash_valid         = valid_q;
    assign bus.hash_value         = hash_q;
    assign bus.image_index_output = idx_q;
    assign bus.busy               = (state != IDLE);
    assign bus.hash_calc_done     = (state == DONE);
endmodule

// File: tb/tb_param_hash_engine.sv
// Directed bench for param_hash_engine at default parameters.
module tb_param_hash_engine;
    localparam int PIX_W = 8;
    localparam int NPIX  = 256;
    localparam int LANES = 4;
    localparam int IDX_W = 16;
    localparam int BEATS = NPIX / LANES;

    localparam logic [NPIX-1:0] EXP_SPOT  = 256'h20;
    localparam logic [NPIX-1:0] EXP_RAMP  = {1'b1, {(NPIX-1){1'b0}}};
    localparam logic [NPIX-1:0] EXP_SPLIT = {{(NPIX/2){1'b1}}, {(NPIX/2){1'b0}}};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    param_hash_engine_if #(.PIX_W(PIX_W), .NPIX(NPIX), .LANES(LANES), .IDX_W(IDX_W)) bus ();

    param_hash_engine #(.PIX_W(PIX_W), .NPIX(NPIX), .LANES(LANES), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;
    logic [PIX_W-1:0] img [NPIX];

    task automatic fill_spot();
        for (int i = 0; i < NPIX; i++) img[i] = 8'd10;
        img[5] = 8'd200;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < NPIX; i++) img[i] = PIX_W'(i);
    endtask

    task automatic fill_split();
        for (int i = 0; i < NPIX; i++) img[i] = (i < NPIX/2) ? 8'd0 : 8'd255;
    endtask

    task automatic start_batch(input logic [IDX_W-1:0] n);
        bus.num_images = n;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.num_images = 16'h0007;
    endtask

    // Header/mode are only correct on beat 0; later beats carry inverted values.
    task automatic send_beats(input int first, input int count, input logic [IDX_W-1:0] hdr,
                              input logic mode, input bit gaps, output bit ok);
        bit acc;
        int t;
        ok = 1'b1;
        for (int b = first; b < first + count; b++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.pix_valid = 1'b0;
                bus.pix_data = '1;
                @(posedge clk); #1;
            end
            for (int k = 0; k < LANES; k++) bus.pix_data[k*PIX_W +: PIX_W] = img[b*LANES + k];
            bus.pix_valid = 1'b1;
            bus.image_header = (b == 0) ? hdr : ~hdr;
            bus.hash_mode = (b == 0) ? mode : ~mode;
            t = 0;
            do begin
                @(negedge clk);
                acc = bus.pix_ready;
                @(posedge clk); #1;
                t++;
            end while (!acc && t < 50);
            if (!acc) begin
                ok = 1'b0;
                break;
            end
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic wait_hash(output int lat, output bit ok);
        lat = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.hash_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic handshake();
        bus.hash_ready = 1'b1;
        @(posedge clk); #1;
        bus.hash_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; #1;
        reset = 1'b0; #10;
        checks++; if ({bus.pix_ready, bus.hash_valid, bus.busy, bus.hash_calc_done} !== 4'b0)
            $display("FAIL reset_ctrl got=%b exp=0000", {bus.pix_ready, bus.hash_valid, bus.busy, bus.hash_calc_done}); else passes++;
        checks++; if (bus.hash_value !== '0) $display("FAIL reset_hash got=%h exp=0", bus.hash_value); else passes++;
        checks++; if (bus.image_index_output !== '0) $display("FAIL reset_idx got=%h exp=0", bus.image_index_output); else passes++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL idle_busy got=%b exp=0", bus.busy); else passes++;
    endtask

    task automatic test_avg_hash();
        bit ok; int lat;
        fill_spot();
        start_batch(16'd1);
        send_beats(0, BEATS, 16'h1234, 1'b0, 1'b0, ok);
        checks++; if (ok !== 1'b1) $display("FAIL avg_load got=timeout exp=accepted"); else passes++;
        wait_hash(lat, ok);
        checks++; if (ok !== 1'b1) $display("FAIL avg_valid got=timeout exp=hash_valid"); else passes++;
        checks++; if (lat !== 65) $display("FAIL avg_latency got=%0d exp=65", lat); else passes++;
        checks++; if (bus.hash_value !== EXP_SPOT) $display("FAIL avg_hash got=%h exp=%h", bus.hash_value, EXP_SPOT); else passes++;
        checks++; if (bus.image_index_output !== 16'h1234) $display("FAIL avg_idx got=%h exp=1234", bus.image_index_output); else passes++;
        checks++; if (bus.pix_ready !== 1'b0) $display("FAIL avg_ready_out got=%b exp=0", bus.pix_ready); else passes++;
        handshake();
        checks++; if (bus.hash_calc_done !== 1'b1) $display("FAIL avg_done got=%b exp=1", bus.hash_calc_done); else passes++;
        checks++; if (bus.hash_value !== EXP_SPOT) $display("FAIL avg_retain got=%h exp=%h", bus.hash_value, EXP_SPOT); else passes++;
        @(posedge clk); #1;
        checks++; if ({bus.hash_calc_done, bus.busy} !== 2'b00) $display("FAIL avg_after_done got=%b exp=00", {bus.hash_calc_done, bus.busy}); else passes++;
    endtask

    task automatic test_diff_hash();
        bit ok; int lat;
        fill_ramp();
        start_batch(16'd1);
        send_beats(0, BEATS, 16'h0BEE, 1'b1, 1'b0, ok);
        wait_hash(lat, ok);
        checks++; if (ok !== 1'b1) $display("FAIL diff_valid got=timeout exp=hash_valid"); else passes++;
        checks++; if (bus.hash_value !== EXP_RAMP) $display("FAIL diff_hash got=%h exp=%h", bus.hash_value, EXP_RAMP); else passes++;
        checks++; if (bus.image_index_output !== 16'h0BEE) $display("FAIL diff_idx got=%h exp=0bee", bus.image_index_output); else passes++;
        handshake();
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit ok; int lat; int pulses;
        start_batch(16'd3);
        fill_spot();
        send_beats(0, BEATS, 16'h0001, 1'b0, 1'b0, ok);
        wait_hash(lat, ok);
        checks++; if ({ok, bus.hash_value} !== {1'b1, EXP_SPOT}) $display("FAIL b2b_hash1 got=%h exp=%h", bus.hash_value, EXP_SPOT); else passes++;
        checks++; if (bus.image_index_output !== 16'h0001) $display("FAIL b2b_idx1 got=%h exp=0001", bus.image_index_output); else passes++;
        handshake();
        checks++; if ({bus.hash_calc_done, bus.pix_ready} !== 2'b01) $display("FAIL b2b_next1 got=%b exp=01", {bus.hash_calc_done, bus.pix_ready}); else passes++;
        fill_ramp();
        send_beats(0, BEATS, 16'h0002, 1'b1, 1'b0, ok);
        wait_hash(lat, ok);
        bus.pix_valid = 1'b1;
        bus.pix_data = '1;
        for (int c = 0; c < 10; c++) begin
            checks++; if ({bus.hash_valid, bus.pix_ready, bus.hash_value} !== {2'b10, EXP_RAMP})
                $display("FAIL b2b_stall c=%0d got=%b%b %h exp=10 %h", c, bus.hash_valid, bus.pix_ready, bus.hash_value, EXP_RAMP); else passes++;
            @(posedge clk); #1;
        end
        bus.pix_valid = 1'b0;
        checks++; if (bus.image_index_output !== 16'h0002) $display("FAIL b2b_idx2 got=%h exp=0002", bus.image_index_output); else passes++;
        handshake();
        checks++; if (bus.hash_calc_done !== 1'b0) $display("FAIL b2b_early_done got=%b exp=0", bus.hash_calc_done); else passes++;
        fill_split();
        send_beats(0, BEATS, 16'h0003, 1'b0, 1'b0, ok);
        wait_hash(lat, ok);
        checks++; if ({ok, bus.hash_value} !== {1'b1, EXP_SPLIT}) $display("FAIL b2b_hash3 got=%h exp=%h", bus.hash_value, EXP_SPLIT); else passes++;
        checks++; if (bus.image_index_output !== 16'h0003) $display("FAIL b2b_idx3 got=%h exp=0003", bus.image_index_output); else passes++;
        handshake();
        checks++; if (bus.hash_calc_done !== 1'b1) $display("FAIL b2b_done got=%b exp=1", bus.hash_calc_done); else passes++;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus.hash_calc_done) pulses++;
        end
        checks++; if (pulses !== 0) $display("FAIL b2b_extra_done got=%0d exp=0", pulses); else passes++;
    endtask

    task automatic test_zero_images();
        start_batch(16'd0);
        checks++; if ({bus.hash_calc_done, bus.pix_ready} !== 2'b10) $display("FAIL zero_done got=%b exp=10", {bus.hash_calc_done, bus.pix_ready}); else passes++;
        @(posedge clk); #1;
        checks++; if ({bus.hash_calc_done, bus.busy, bus.pix_ready} !== 3'b000) $display("FAIL zero_after got=%b exp=000", {bus.hash_calc_done, bus.busy, bus.pix_ready}); else passes++;
    endtask

    task automatic test_reset_mid();
        bit ok; int lat; int pulses;
        fill_spot();
        start_batch(16'd1);
        send_beats(0, 20, 16'h1234, 1'b0, 1'b0, ok);
        #2 reset = 1'b0;
        #1;
        checks++; if ({bus.pix_ready, bus.hash_valid, bus.busy, bus.hash_calc_done} !== 4'b0)
            $display("FAIL mid_ctrl got=%b exp=0000", {bus.pix_ready, bus.hash_valid, bus.busy, bus.hash_calc_done}); else passes++;
        checks++; if (bus.hash_value !== '0) $display("FAIL mid_hash got=%h exp=0", bus.hash_value); else passes++;
        checks++; if (bus.image_index_output !== '0) $display("FAIL mid_idx got=%h exp=0", bus.image_index_output); else passes++;
        @(posedge clk); #1;
        reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (bus.hash_calc_done || bus.busy) pulses++;
        end
        checks++; if (pulses !== 0) $display("FAIL mid_quiet got=%0d exp=0", pulses); else passes++;
        start_batch(16'd1);
        send_beats(0, BEATS, 16'h1234, 1'b0, 1'b1, ok);
        wait_hash(lat, ok);
        checks++; if (lat !== 65) $display("FAIL mid_latency got=%0d exp=65", lat); else passes++;
        checks++; if (bus.hash_value !== EXP_SPOT) $display("FAIL mid_gap_hash got=%h exp=%h", bus.hash_value, EXP_SPOT); else passes++;
        checks++; if (bus.image_index_output !== 16'h1234) $display("FAIL mid_gap_idx got=%h exp=1234", bus.image_index_output); else passes++;
        handshake();
        checks++; if (bus.hash_calc_done !== 1'b1) $display("FAIL mid_done got=%b exp=1", bus.hash_calc_done); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_start_while_busy();
        bit ok; int lat;
        fill_spot();
        start_batch(16'd2);
        send_beats(0, 10, 16'h000A, 1'b0, 1'b0, ok);
        start_batch(16'd1);
        send_beats(10, BEATS - 10, 16'h000A, 1'b0, 1'b0, ok);
        checks++; if (ok !== 1'b1) $display("FAIL busy_load got=timeout exp=accepted"); else passes++;
        wait_hash(lat, ok);
        checks++; if (lat !== 65) $display("FAIL busy_latency got=%0d exp=65", lat); else passes++;
        checks++; if (bus.hash_value !== EXP_SPOT) $display("FAIL busy_hash1 got=%h exp=%h", bus.hash_value, EXP_SPOT); else passes++;
        handshake();
        checks++; if ({bus.hash_calc_done, bus.pix_ready} !== 2'b01) $display("FAIL busy_next got=%b exp=01", {bus.hash_calc_done, bus.pix_ready}); else passes++;
        fill_ramp();
        send_beats(0, BEATS, 16'h000B, 1'b1, 1'b0, ok);
        wait_hash(lat, ok);
        checks++; if ({ok, bus.hash_value} !== {1'b1, EXP_RAMP}) $display("FAIL busy_hash2 got=%h exp=%h", bus.hash_value, EXP_RAMP); else passes++;
        checks++; if (bus.image_index_output !== 16'h000B) $display("FAIL busy_idx2 got=%h exp=000b", bus.image_index_output); else passes++;
        handshake();
        checks++; if (bus.hash_calc_done !== 1'b1) $display("FAIL busy_done got=%b exp=1", bus.hash_calc_done); else passes++;
        @(posedge clk); #1;
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.num_images   = '0;
        bus.hash_mode    = 1'b0;
        bus.image_header = '0;
        bus.pix_data     = '0;
        bus.pix_valid    = 1'b0;
        bus.hash_ready   = 1'b0;
        test_reset();
        test_avg_hash();
        test_diff_hash();
        test_back_to_back();
        test_zero_images();
        test_reset_mid();
        test_start_while_busy();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
